// File: rtl/mem_access_ctrl.sv
// Load/store access sequencer between the pipeline and a byte-addressed
// data memory; halfwords are split into two byte accesses.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 4096,
  parameter int OP_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic            dm_wren,
  output logic            dm_sb,
  output logic            dm_lb,
  output logic            dm_lbu,
  output logic [31:0]     dm_addr,
  output logic [31:0]     dm_wdata,
  input  logic [31:0]     dm_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_t;

  localparam logic [OP_W-1:0] OP_LW  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_err;
  logic [31:0]     r_lo;
  logic [7:0]      r_hi;

  logic [32:0] w_size;
  logic [32:0] w_end;
  logic        w_oob;

  logic w_lw, w_lb, w_lbu, w_lh, w_lhu;
  logic w_sw, w_sb, w_sh;
  logic w_load, w_store, w_half;
  logic [31:0] w_rdata;

  // 33-bit end address so accesses near 2^32 cannot wrap into range
  always_comb begin
    w_size = 33'd4;
    if (req_op == OP_LB || req_op == OP_LBU || req_op == OP_SB)
      w_size = 33'd1;
    else if (req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH)
      w_size = 33'd2;
  end

  assign w_end = {1'b0, req_addr} + w_size;
  assign w_oob = w_end > 33'(MEM_BYTES);

  assign w_lw  = (r_op == OP_LW);
  assign w_lb  = (r_op == OP_LB);
  assign w_lbu = (r_op == OP_LBU);
  assign w_lh  = (r_op == OP_LH);
  assign w_lhu = (r_op == OP_LHU);
  assign w_sw  = (r_op == OP_SW);
  assign w_sb  = (r_op == OP_SB);
  assign w_sh  = (r_op == OP_SH);

  assign w_load  = w_lw | w_lb | w_lbu | w_lh | w_lhu;
  assign w_store = w_sw | w_sb | w_sh;
  assign w_half  = w_lh | w_lhu | w_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_oob;
      end
      if (r_state == ACC0 && w_load)
        r_lo <= dm_rdata;
      if (r_state == ACC1 && w_load)
        r_hi <= dm_rdata[7:0];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (req_valid) w_next = w_oob ? RESP : ACC0;
      ACC0: w_next = w_half ? ACC1 : RESP;
      ACC1: w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_lw, w_lb, w_lbu: w_rdata = r_lo;
      w_lh: w_rdata = {{16{r_hi[7]}}, r_hi, r_lo[7:0]};
      w_lhu: w_rdata = {16'b0, r_hi, r_lo[7:0]};
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    dm_wren   = 1'b0;
    dm_sb     = 1'b0;
    dm_lb     = 1'b0;
    dm_lbu    = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    unique case (r_state)
      ACC0: begin
        dm_addr = r_addr;
        dm_wren = w_store;
        dm_lb   = w_lb;
        dm_lbu  = w_lbu | w_lh | w_lhu;
        dm_sb   = w_sb | w_sh;
        if (w_sw)
          dm_wdata = r_wdata;
        else if (w_sb | w_sh)
          dm_wdata = {24'b0, r_wdata[7:0]};
      end
      ACC1: begin
        dm_addr = r_addr + 32'd1;
        if (w_sh) begin
          dm_sb    = 1'b1;
          dm_wren  = 1'b1;
          dm_wdata = {24'b0, r_wdata[15:8]};
        end else begin
          dm_lbu = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = r_err ? 32'b0 : w_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array memory model
// that commits writes on the falling clock edge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dm_wren;
  logic        dm_sb;
  logic        dm_lb;
  logic        dm_lbu;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  logic [7:0] mem [0:4095] = '{default: 8'h00};
  int wcount = 0;
  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.MEM_BYTES(4096), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_wren(dm_wren), .dm_sb(dm_sb), .dm_lb(dm_lb), .dm_lbu(dm_lbu),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  wire [11:0] a0 = dm_addr[11:0];
  wire [11:0] a1 = a0 + 12'd1;
  wire [11:0] a2 = a0 + 12'd2;
  wire [11:0] a3 = a0 + 12'd3;

  assign dm_rdata = dm_lb  ? {{24{mem[a0][7]}}, mem[a0]} :
                    dm_lbu ? {24'b0, mem[a0]} :
                    {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(negedge clk) begin
    if (dm_wren) begin
      wcount = wcount + 1;
      if (dm_sb) begin
        mem[a0] = dm_wdata[7:0];
      end else begin
        mem[a0] = dm_wdata[7:0];
        mem[a1] = dm_wdata[15:8];
        mem[a2] = dm_wdata[23:16];
        mem[a3] = dm_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er,
                        output int wr);
    int w0;
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    w0 = wcount;
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    rd = 'x;
    er = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        rd = rsp_rdata;
        er = rsp_err;
        break;
      end
    end
    wr = wcount - w0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int wr;
    int nr;
    int stage;
    int pulses;
    logic [31:0] rd;
    logic er;
    logic [31:0] resp [0:3];

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_addr = '0;
    req_wdata = '0;
    #12;
    chk("rst_ctl", {req_ready, rsp_valid, rsp_err, dm_wren, dm_sb,
                    dm_lb, dm_lbu}, 32'h40);
    chk("rst_data", rsp_rdata | dm_addr | dm_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // word store then load
    do_req(3'd5, 32'h10, 32'h11223344, lat, rd, er, wr);
    chk("sw_lat", lat, 2);
    chk("sw_rdata", rd, 0);
    chk("sw_err", er, 0);
    chk("sw_wren_cycles", wr, 1);
    do_req(3'd0, 32'h10, 32'h0, lat, rd, er, wr);
    chk("lw_lat", lat, 2);
    chk("lw_rdata", rd, 32'h11223344);
    chk("lw_nowrite", wr, 0);

    // byte store and signed/unsigned byte loads
    do_req(3'd6, 32'h20, 32'hAAAAAA80, lat, rd, er, wr);
    chk("sb_lat", lat, 2);
    chk("sb_mem21", mem[12'h21], 0);
    do_req(3'd1, 32'h20, 32'h0, lat, rd, er, wr);
    chk("lb_lat", lat, 2);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    do_req(3'd2, 32'h20, 32'h0, lat, rd, er, wr);
    chk("lbu_rdata", rd, 32'h00000080);

    // misaligned halfword store and loads
    do_req(3'd7, 32'h31, 32'h0000BEEF, lat, rd, er, wr);
    chk("sh_lat", lat, 3);
    chk("sh_writes", wr, 2);
    chk("sh_bytes", {mem[12'h30], mem[12'h31], mem[12'h32], mem[12'h33]},
        32'h00EFBE00);
    do_req(3'd3, 32'h31, 32'h0, lat, rd, er, wr);
    chk("lh_lat", lat, 3);
    chk("lh_rdata", rd, 32'hFFFFBEEF);
    do_req(3'd4, 32'h31, 32'h0, lat, rd, er, wr);
    chk("lhu_rdata", rd, 32'h0000BEEF);
    do_req(3'd0, 32'h31, 32'h0, lat, rd, er, wr);
    chk("lw_misaligned", rd, 32'h0000BEEF);

    // range boundary
    do_req(3'd5, 32'hFFC, 32'hD4C3B2A1, lat, rd, er, wr);
    chk("sw_top_err", er, 0);
    do_req(3'd6, 32'hFFF, 32'h5A, lat, rd, er, wr);
    chk("sb_last_err", er, 0);
    do_req(3'd0, 32'hFFC, 32'h0, lat, rd, er, wr);
    chk("lw_top_err", er, 0);
    chk("lw_top_rdata", rd, 32'h5AC3B2A1);
    do_req(3'd0, 32'hFFD, 32'h0, lat, rd, er, wr);
    chk("lw_oob_lat", lat, 1);
    chk("lw_oob_err", er, 1);
    chk("lw_oob_rdata", rd, 0);
    do_req(3'd5, 32'hFFFFFFFE, 32'hDEADBEEF, lat, rd, er, wr);
    chk("sw_wrap_lat", lat, 1);
    chk("sw_wrap_err", er, 1);
    chk("sw_wrap_nowrite", wr, 0);
    do_req(3'd7, 32'hFFF, 32'h1234, lat, rd, er, wr);
    chk("sh_oob_err", er, 1);
    chk("sh_oob_nowrite", wr, 0);

    // back-to-back with req_valid held high
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd5;
    req_addr = 32'h40;
    req_wdata = 32'hCAFEBABE;
    nr = 0;
    stage = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (stage == 0) begin
        req_op = 3'd0;
        req_wdata = 32'h0;
        stage = 1;
      end else if (stage == 2) begin
        req_valid = 1'b0;
        stage = 3;
      end
      @(negedge clk);
      if (rsp_valid && nr < 4) begin
        resp[nr] = rsp_rdata;
        nr++;
      end
      if (stage == 1 && req_ready) stage = 2;
    end
    chk("b2b_count", nr, 2);
    chk("b2b_first", resp[0], 0);
    chk("b2b_second", resp[1], 32'hCAFEBABE);

    // reset in the second byte phase of a halfword store
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd7;
    req_addr = 32'h50;
    req_wdata = 32'h00001234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("acc1_wren", dm_wren, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {req_ready, rsp_valid, rsp_err, dm_wren, dm_sb,
                       dm_lb, dm_lbu}, 32'h40);
    chk("midrst_data", rsp_rdata | dm_addr | dm_wdata, 32'h0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("midrst_no_rsp", pulses, 0);
    chk("midrst_bytes", {mem[12'h50], mem[12'h51]}, 32'h3400);

    // first request after reset release
    do_req(3'd0, 32'h50, 32'h0, lat, rd, er, wr);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_rdata", rd, 32'h00000034);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
